// File: rtl/jtdd_pkg.sv
// Shared definitions for the MCU shared-RAM arbiter: FSM state encoding
// and a helper that tells which states keep the MCU halt request asserted.
package jtdd_pkg;

    localparam int ST_W = 3;

    localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [ST_W-1:0] ST_REQ   = 3'd1;
    localparam logic [ST_W-1:0] ST_GRANT = 3'd2;
    localparam logic [ST_W-1:0] ST_HOLD  = 3'd3;
    localparam logic [ST_W-1:0] ST_REL   = 3'd4;

    function automatic logic halt_state(input logic [ST_W-1:0] st);
        logic r;
        case (st)
            ST_REQ, ST_GRANT, ST_HOLD: r = 1'b1;
            default:                   r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/jtdd_arb_cnt.sv
// cen-gated saturating counter with synchronous clear; hit flags the
// count value LIM-1 so the owner can act on the LIM-th enabled cycle.
module jtdd_arb_cnt #(
    parameter int CW  = 7,
    parameter int LIM = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic cen,
    input  logic clr,
    output logic hit
);

    localparam logic [CW-1:0] HIT_VAL = CW'(LIM - 1);
    localparam logic [CW-1:0] MAX_VAL = {CW{1'b1}};
    localparam logic [CW-1:0] ONE     = {{(CW-1){1'b0}}, 1'b1};

    logic [CW-1:0] cnt_r;

    // Count cen pulses while not cleared, sticking at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CW{1'b0}};
        end else if (clr) begin
            cnt_r <= {CW{1'b0}};
        end else if (cen && (cnt_r != MAX_VAL)) begin
            cnt_r <= cnt_r + ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign hit = (cnt_r == HIT_VAL);

endmodule

// File: rtl/jtdd_mcu_arb.sv
// Shared-RAM arbiter between the main CPU and the 6801 MCU: halts the MCU
// for main-CPU accesses, stalls the CPU until halted, and paces NMI pulses.
module jtdd_mcu_arb
    import jtdd_pkg::*;
#(
    parameter int HOLD = 4,
    parameter int TOUT = 64,
    parameter int CW   = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic cen,
    input  logic cpu_cs,
    input  logic cpu_wrn,
    input  logic nmi_wr,
    output logic cpu_waitn,
    output logic mcu_halt,
    input  logic halted,
    output logic mcu_nmi_set,
    output logic sh_we,
    output logic tout_flag
);

    logic [ST_W-1:0] state_r;
    logic [ST_W-1:0] state_nxt_s;
    logic            tout_hit_s;
    logic            hold_hit_s;
    logic            grant_halted_s;
    logic            grant_tout_s;
    logic            tout_grant_r;
    logic            tout_flag_r;
    logic            mcu_halt_r;
    logic            nmi_wr_d_r;
    logic            nmi_pend_r;
    logic            nmi_edge_s;
    logic            nmi_fire_s;
    logic            cpu_waitn_s;

    jtdd_arb_cnt #(.CW(CW), .LIM(TOUT)) u_tcnt (
        .clk (clk),
        .rst (rst),
        .cen (cen),
        .clr (state_r != ST_REQ),
        .hit (tout_hit_s)
    );

    jtdd_arb_cnt #(.CW(CW), .LIM(HOLD)) u_hcnt (
        .clk (clk),
        .rst (rst),
        .cen (cen),
        .clr (state_r != ST_HOLD),
        .hit (hold_hit_s)
    );

    // Next-state decode; halted beats a coincident timeout in REQ
    always_comb begin
        state_nxt_s    = state_r;
        grant_halted_s = 1'b0;
        grant_tout_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cpu_cs) begin
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (halted) begin
                    state_nxt_s    = ST_GRANT;
                    grant_halted_s = 1'b1;
                end else if (cen && tout_hit_s) begin
                    state_nxt_s  = ST_GRANT;
                    grant_tout_s = 1'b1;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_GRANT: begin
                if (!cpu_cs) begin
                    state_nxt_s = ST_HOLD;
                end else begin
                    state_nxt_s = ST_GRANT;
                end
            end
            ST_HOLD: begin
                if (cpu_cs) begin
                    state_nxt_s = ST_GRANT;
                end else if (cen && hold_hit_s) begin
                    state_nxt_s = ST_REL;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            ST_REL: begin
                if (!halted) begin
                    state_nxt_s = cpu_cs ? ST_REQ : ST_IDLE;
                end else begin
                    state_nxt_s = ST_REL;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, halt request and timeout bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            mcu_halt_r   <= 1'b0;
            tout_grant_r <= 1'b0;
            tout_flag_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            mcu_halt_r <= halt_state(state_nxt_s);
            // A forced grant stays forced across HOLD re-grants of the same halt
            if (grant_tout_s) begin
                tout_grant_r <= 1'b1;
            end else if (grant_halted_s) begin
                tout_grant_r <= 1'b0;
            end else begin
                tout_grant_r <= tout_grant_r;
            end
            tout_flag_r <= tout_flag_r | grant_tout_s;
        end
    end

    // CPU wait decode; IDLE and REL stall a fresh cs in the same clk
    always_comb begin
        cpu_waitn_s = 1'b1;
        case (state_r)
            ST_IDLE:  cpu_waitn_s = ~cpu_cs;
            ST_REQ:   cpu_waitn_s = 1'b0;
            ST_GRANT: cpu_waitn_s = 1'b1;
            ST_HOLD:  cpu_waitn_s = 1'b1;
            ST_REL:   cpu_waitn_s = ~cpu_cs;
            default:  cpu_waitn_s = 1'b1;
        endcase
    end

    assign nmi_edge_s = nmi_wr & ~nmi_wr_d_r;
    assign nmi_fire_s = nmi_pend_r & (state_r == ST_IDLE) & ~halted;

    // NMI latch: an edge in the firing clk re-arms the pending flag
    always_ff @(posedge clk) begin
        if (rst) begin
            nmi_wr_d_r <= 1'b0;
            nmi_pend_r <= 1'b0;
        end else begin
            nmi_wr_d_r <= nmi_wr;
            nmi_pend_r <= nmi_edge_s | (nmi_pend_r & ~nmi_fire_s);
        end
    end

    assign cpu_waitn   = cpu_waitn_s;
    assign mcu_halt    = mcu_halt_r;
    assign mcu_nmi_set = nmi_fire_s;
    assign sh_we       = (state_r == ST_GRANT) & ~cpu_wrn & cpu_cs & (halted | tout_grant_r);
    assign tout_flag   = tout_flag_r;

endmodule

// File: tb/tb_jtdd_mcu_arb.sv
// Randomised bench for jtdd_mcu_arb against a cycle-level behavioural model.
module tb_jtdd_mcu_arb;

    localparam int HOLD = 4;
    localparam int TOUT = 64;
    localparam int CW   = 7;

    logic clk = 1'b0;
    logic rst, cen, cpu_cs, cpu_wrn, nmi_wr, halted;
    logic cpu_waitn, mcu_halt, mcu_nmi_set, sh_we, tout_flag;

    always #5 clk = ~clk;

    jtdd_mcu_arb #(.HOLD(HOLD), .TOUT(TOUT), .CW(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .cen         (cen),
        .cpu_cs      (cpu_cs),
        .cpu_wrn     (cpu_wrn),
        .nmi_wr      (nmi_wr),
        .cpu_waitn   (cpu_waitn),
        .mcu_halt    (mcu_halt),
        .halted      (halted),
        .mcu_nmi_set (mcu_nmi_set),
        .sh_we       (sh_we),
        .tout_flag   (tout_flag)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // behavioural model: halt requested / bus granted / cs dropped while granted / releasing
    bit m_req, m_granted, m_linger, m_release, m_forced, m_tout, m_pend, m_nmi_prev;
    int m_waited, m_quiet;
    bit e_waitn, e_halt, e_we, e_nmi;

    // stimulus control
    int cen_mode, mcu_mode, hdelay, cs_left, gap, nmi_pulses, n;
    bit cpu_auto, nmi_rand;

    task automatic model_clear();
        m_req = 0; m_granted = 0; m_linger = 0; m_release = 0;
        m_forced = 0; m_tout = 0; m_pend = 0; m_nmi_prev = 0;
        m_waited = 0; m_quiet = 0;
    endtask

    task automatic model_outputs();
        bit idle;
        idle   = !m_req && !m_release;
        e_halt = m_req;
        if (m_granted)  e_waitn = 1'b1;
        else if (m_req) e_waitn = 1'b0;
        else            e_waitn = !cpu_cs;
        e_we  = m_granted && !m_linger && cpu_cs && !cpu_wrn && (halted || m_forced);
        e_nmi = m_pend && idle && !halted;
    endtask

    task automatic model_advance();
        bit edge_s;
        if (rst) begin
            model_clear();
            return;
        end
        edge_s     = nmi_wr && !m_nmi_prev;
        m_pend     = edge_s || (m_pend && !e_nmi);
        m_nmi_prev = nmi_wr;
        if (m_release) begin
            if (!halted) begin
                m_release = 0;
                if (cpu_cs) begin m_req = 1; m_waited = 0; end
            end
        end else if (!m_req) begin
            if (cpu_cs) begin m_req = 1; m_waited = 0; end
        end else if (!m_granted) begin
            if (halted) begin
                m_granted = 1; m_forced = 0;
            end else if (cen) begin
                if (m_waited == TOUT - 1) begin m_granted = 1; m_forced = 1; m_tout = 1; end
                else m_waited++;
            end
        end else if (!m_linger) begin
            if (!cpu_cs) begin m_linger = 1; m_quiet = 0; end
        end else begin
            if (cpu_cs) m_linger = 0;
            else if (cen) begin
                if (m_quiet == HOLD - 1) begin
                    m_req = 0; m_granted = 0; m_linger = 0; m_release = 1;
                end else m_quiet++;
            end
        end
    endtask

    task automatic drive();
        cen = (cen_mode != 0) ? 1'b1 : 1'($urandom_range(0, 1));
        case (mcu_mode)
            0: begin
                if (mcu_halt !== halted) begin
                    if (hdelay == 0) begin
                        halted = mcu_halt;
                        hdelay = $urandom_range(0, 4);
                    end else hdelay--;
                end
            end
            2: if (m_req && !m_granted && m_waited == TOUT - 1) halted = 1'b1;
            default: halted = 1'b0;
        endcase
        if (cpu_auto) begin
            if (cpu_cs && cs_left == 0) begin
                cpu_cs = 1'b0;
                gap    = $urandom_range(0, 12);
            end else if (!cpu_cs) begin
                if (gap == 0) begin
                    cpu_cs  = 1'b1;
                    cpu_wrn = 1'($urandom_range(0, 1));
                    cs_left = $urandom_range(1, 3);
                end else gap--;
            end
        end
        if (nmi_rand && $urandom_range(0, 9) == 0) nmi_wr = !nmi_wr;
    endtask

    task automatic cycle();
        @(negedge clk);
        model_outputs();
        check_val("cpu_waitn",   32'(cpu_waitn),   32'(e_waitn));
        check_val("mcu_halt",    32'(mcu_halt),    32'(e_halt));
        check_val("sh_we",       32'(sh_we),       32'(e_we));
        check_val("mcu_nmi_set", 32'(mcu_nmi_set), 32'(e_nmi));
        check_val("tout_flag",   32'(tout_flag),   32'(m_tout));
        if (mcu_nmi_set === 1'b1) nmi_pulses++;
        if (cpu_cs && e_waitn && cs_left > 0) cs_left--;
        model_advance();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic drain();
        int k;
        cpu_auto = 0; nmi_rand = 0; cpu_cs = 1'b0; nmi_wr = 1'b0;
        mcu_mode = 0; cs_left = 0; cpu_wrn = 1'b1;
        k = 0;
        while ((m_req || m_release || halted) && k < 300) begin
            cycle();
            k++;
        end
        repeat (2) cycle();
        check_val("drain_halt", 32'(mcu_halt), 32'd0);
    endtask

    initial begin
        rst = 1'b1; cen = 1'b1; cpu_cs = 1'b0; cpu_wrn = 1'b1; nmi_wr = 1'b0; halted = 1'b0;
        cen_mode = 1; mcu_mode = 0; hdelay = 0; cs_left = 0; gap = 0; nmi_pulses = 0;
        cpu_auto = 0; nmi_rand = 0;
        repeat (3) @(posedge clk);
        #1;
        model_clear();
        @(negedge clk);
        check_val("rst_waitn", 32'(cpu_waitn),   32'd1);
        check_val("rst_halt",  32'(mcu_halt),    32'd0);
        check_val("rst_we",    32'(sh_we),       32'd0);
        check_val("rst_nmi",   32'(mcu_nmi_set), 32'd0);
        check_val("rst_tout",  32'(tout_flag),   32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // random traffic with a responsive MCU
        cpu_auto = 1; nmi_rand = 1; cen_mode = 0;
        repeat (2000) cycle();

        // halted arrives on the very cen that would time out
        drain();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cen_mode = 1; cen = 1'b1; mcu_mode = 2; halted = 1'b0; cpu_wrn = 1'b0; cpu_cs = 1'b1;
        n = 0;
        while (!m_granted && n < 200) begin cycle(); n++; end
        #1;
        check_val("coinc_lat",  32'(n),         32'd65);
        check_val("coinc_tout", 32'(tout_flag), 32'd0);
        check_val("coinc_we",   32'(sh_we),     32'd1);
        mcu_mode = 0; cpu_cs = 1'b0; cpu_wrn = 1'b1;
        repeat (20) cycle();

        // MCU never halts: forced grant after TOUT cens
        drain();
        cen_mode = 1; cen = 1'b1; mcu_mode = 1; halted = 1'b0; cpu_wrn = 1'b1; cpu_cs = 1'b1;
        n = 0;
        while (!m_granted && n < 200) begin cycle(); n++; end
        #1;
        check_val("tout_lat",   32'(n),         32'd65);
        check_val("tout_flag1", 32'(tout_flag), 32'd1);
        check_val("tout_rd_we", 32'(sh_we),     32'd0);
        cpu_wrn = 1'b0;
        #1;
        check_val("tout_wr_we", 32'(sh_we),     32'd1);
        cycle();
        cpu_cs = 1'b0; cpu_wrn = 1'b1;
        repeat (20) cycle();

        // reset while in REQ with an NMI pending
        drain();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cen_mode = 0; mcu_mode = 1; cpu_cs = 1'b1; cpu_wrn = 1'b1;
        repeat (3) cycle();
        nmi_wr = 1'b1;
        cycle();
        cycle();
        rst = 1'b1; cpu_cs = 1'b0; nmi_wr = 1'b0;
        cycle();
        rst = 1'b0;
        #1;
        check_val("rstreq_halt",  32'(mcu_halt),  32'd0);
        check_val("rstreq_waitn", 32'(cpu_waitn), 32'd1);
        nmi_pulses = 0; mcu_mode = 0;
        repeat (6) cycle();
        check_val("rstreq_nmi", 32'(nmi_pulses), 32'd0);

        // three NMI edges during GRANT collapse into one pulse once idle
        drain();
        cen_mode = 1; cen = 1'b1; mcu_mode = 0; cpu_cs = 1'b1; cpu_wrn = 1'b1;
        n = 0;
        while (!m_granted && n < 50) begin cycle(); n++; end
        #1;
        check_val("nmi_granted", 32'(cpu_waitn), 32'd1);
        nmi_pulses = 0;
        repeat (3) begin
            nmi_wr = 1'b1; cycle();
            nmi_wr = 1'b0; cycle();
        end
        check_val("nmi_in_grant", 32'(nmi_pulses), 32'd0);
        cpu_cs = 1'b0;
        repeat (60) cycle();
        check_val("nmi_once", 32'(nmi_pulses), 32'd1);

        // random traffic alternating responsive and stuck MCU
        drain();
        cpu_auto = 1; nmi_rand = 1; cen_mode = 0;
        for (int k = 0; k < 6; k++) begin
            mcu_mode = k % 2;
            repeat (300) cycle();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
